// File: rtl/qsn_pkg.sv
// Shared constants, select encoding and tracker entry type for the 17-lane QSN scheduler.
package qsn_pkg;

   localparam int Z       = 17;
   localparam int SEL_W   = 5;
   localparam int MRG_W   = 16;
   localparam int QSN_LAT = 2;
   localparam int TAG_W   = 8;

   localparam logic [SEL_W-1:0] Z_SEL = SEL_W'(Z);

   typedef struct packed {
      logic [SEL_W-1:0] left;
      logic [SEL_W-1:0] right;
      logic [MRG_W-1:0] merge;
   } qsn_sel_t;

   typedef struct packed {
      logic             valid;
      logic             src;
      logic [TAG_W-1:0] tag;
   } qsn_trk_t;

   // Out-of-range shifts collapse to an identity shift so the QSN never sees an illegal select.
   function automatic qsn_sel_t shift_to_sel(input logic [SEL_W-1:0] s);
      qsn_sel_t         r;
      logic [SEL_W-1:0] se;
      se      = (s >= Z_SEL) ? '0 : s;
      r.left  = se;
      r.right = (se == '0) ? '0 : (Z_SEL - se);
      r.merge = {MRG_W{1'b1}} >> se;
      return r;
   endfunction

endpackage

// File: rtl/qsn_rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the port that wins a tie.
module qsn_rr_arb2 (
   input  logic clk,
   input  logic rst_n,
   input  logic req_a,
   input  logic req_b,
   output logic gnt_a,
   output logic gnt_b
);

   logic ptr_q;
   logic ptr_d;

   always_comb begin
      gnt_a = req_a & (~req_b | ~ptr_q);
      gnt_b = req_b & (~req_a |  ptr_q);
      ptr_d = ptr_q;
      if (gnt_a) begin
         ptr_d = 1'b1;
      end else if (gnt_b) begin
         ptr_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/qsn_shift_sched_len17.sv
// Arbitrates two shift requesters onto the QSN, encodes the selects and tracks each
// request through the shifter pipeline so sw_out can be attributed to its owner.
module qsn_shift_sched_len17
   import qsn_pkg::*;
(
   input  logic             sys_clk,
   input  logic             rstn,
   input  logic             a_valid,
   output logic             a_ready,
   input  logic [SEL_W-1:0] a_shift,
   input  logic [TAG_W-1:0] a_tag,
   input  logic             b_valid,
   output logic             b_ready,
   input  logic [SEL_W-1:0] b_shift,
   input  logic [TAG_W-1:0] b_tag,
   output logic [SEL_W-1:0] left_sel,
   output logic [SEL_W-1:0] right_sel,
   output logic [MRG_W-1:0] merge_sel,
   output logic             sel_valid,
   output logic             out_valid,
   output logic             out_src,
   output logic [TAG_W-1:0] out_tag,
   output logic             shift_err,
   output logic [15:0]      issue_cnt
);

   logic             gnt_a;
   logic             gnt_b;
   logic             hs;
   logic [SEL_W-1:0] g_shift;
   logic [TAG_W-1:0] g_tag;

   qsn_sel_t         sel_q,       sel_d;
   logic             sel_valid_q, sel_valid_d;
   logic             sel_src_q,   sel_src_d;
   logic [TAG_W-1:0] sel_tag_q,   sel_tag_d;
   logic             shift_err_q, shift_err_d;
   logic [15:0]      issue_cnt_q, issue_cnt_d;
   qsn_trk_t         trk_q [QSN_LAT];
   qsn_trk_t         trk_d [QSN_LAT];

   qsn_rr_arb2 u_arb (
      .clk   (sys_clk),
      .rst_n (rstn),
      .req_a (a_valid),
      .req_b (b_valid),
      .gnt_a (gnt_a),
      .gnt_b (gnt_b)
   );

   assign a_ready = gnt_a;
   assign b_ready = gnt_b;
   assign hs      = gnt_a | gnt_b;

   always_comb begin
      g_shift     = gnt_b ? b_shift : a_shift;
      g_tag       = gnt_b ? b_tag   : a_tag;
      // Selects hold on idle cycles so the QSN datapath does not toggle.
      sel_d       = sel_q;
      sel_src_d   = sel_src_q;
      sel_tag_d   = sel_tag_q;
      sel_valid_d = hs;
      shift_err_d = 1'b0;
      if (hs) begin
         sel_d       = shift_to_sel(g_shift);
         sel_src_d   = gnt_b;
         sel_tag_d   = g_tag;
         shift_err_d = (g_shift >= Z_SEL);
      end

      trk_d[0].valid = sel_valid_q;
      trk_d[0].src   = sel_src_q;
      trk_d[0].tag   = sel_tag_q;
      for (int i = 1; i < QSN_LAT; i++) begin
         trk_d[i] = trk_q[i-1];
      end

      issue_cnt_d = issue_cnt_q;
      if (hs && (issue_cnt_q != 16'hFFFF)) begin
         issue_cnt_d = issue_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn) begin
         sel_q       <= '0;
         sel_valid_q <= 1'b0;
         sel_src_q   <= 1'b0;
         sel_tag_q   <= '0;
         shift_err_q <= 1'b0;
         issue_cnt_q <= '0;
         for (int i = 0; i < QSN_LAT; i++) begin
            trk_q[i] <= '0;
         end
      end else begin
         sel_q       <= sel_d;
         sel_valid_q <= sel_valid_d;
         sel_src_q   <= sel_src_d;
         sel_tag_q   <= sel_tag_d;
         shift_err_q <= shift_err_d;
         issue_cnt_q <= issue_cnt_d;
         for (int i = 0; i < QSN_LAT; i++) begin
            trk_q[i] <= trk_d[i];
         end
      end
   end

   assign left_sel  = sel_q.left;
   assign right_sel = sel_q.right;
   assign merge_sel = sel_q.merge;
   assign sel_valid = sel_valid_q;
   assign shift_err = shift_err_q;
   assign issue_cnt = issue_cnt_q;
   assign out_valid = trk_q[QSN_LAT-1].valid;
   assign out_src   = trk_q[QSN_LAT-1].src;
   assign out_tag   = trk_q[QSN_LAT-1].tag;

endmodule

// File: tb/tb_qsn_shift_sched_len17.sv
// Directed and random stimulus for the QSN shift scheduler against a cycle-history reference model.
module tb_qsn_shift_sched_len17;

   logic        sys_clk = 1'b0;
   logic        rstn    = 1'b0;
   logic        a_valid = 1'b0;
   logic        a_ready;
   logic [4:0]  a_shift = '0;
   logic [7:0]  a_tag   = '0;
   logic        b_valid = 1'b0;
   logic        b_ready;
   logic [4:0]  b_shift = '0;
   logic [7:0]  b_tag   = '0;
   logic [4:0]  left_sel;
   logic [4:0]  right_sel;
   logic [15:0] merge_sel;
   logic        sel_valid;
   logic        out_valid;
   logic        out_src;
   logic [7:0]  out_tag;
   logic        shift_err;
   logic [15:0] issue_cnt;

   always #5 sys_clk = ~sys_clk;

   qsn_shift_sched_len17 dut (
      .sys_clk   (sys_clk),
      .rstn      (rstn),
      .a_valid   (a_valid),
      .a_ready   (a_ready),
      .a_shift   (a_shift),
      .a_tag     (a_tag),
      .b_valid   (b_valid),
      .b_ready   (b_ready),
      .b_shift   (b_shift),
      .b_tag     (b_tag),
      .left_sel  (left_sel),
      .right_sel (right_sel),
      .merge_sel (merge_sel),
      .sel_valid (sel_valid),
      .out_valid (out_valid),
      .out_src   (out_src),
      .out_tag   (out_tag),
      .shift_err (shift_err),
      .issue_cnt (issue_cnt)
   );

   typedef struct {
      logic       v;
      logic       src;
      logic [7:0] tag;
      int         shift;
   } rec_t;

   rec_t        hist[$];
   int          total = 0;
   int          bad   = 0;
   logic        m_ptr;
   int          m_cnt;
   int          m_left, m_right;
   logic [15:0] m_merge;
   logic        last_ga, last_gb;
   logic        srcs[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      rec_t e;
      e.v = 1'b0; e.src = 1'b0; e.tag = '0; e.shift = 0;
      hist = {};
      for (int i = 0; i < 3; i++) hist.push_back(e);
      m_ptr = 1'b0; m_cnt = 0; m_left = 0; m_right = 0; m_merge = '0;
   endtask

   // One clock: check ready, advance model, check registered outputs after the edge.
   task automatic step();
      rec_t r, rs, ro;
      int   e;
      #1;
      last_ga = a_valid && (!b_valid || !m_ptr);
      last_gb = b_valid && (!a_valid ||  m_ptr);
      chk("a_ready", a_ready, last_ga);
      chk("b_ready", b_ready, last_gb);
      r.v     = last_ga || last_gb;
      r.src   = last_gb;
      r.tag   = last_gb ? b_tag : a_tag;
      r.shift = last_gb ? int'(b_shift) : int'(a_shift);
      if (last_ga) m_ptr = 1'b1;
      else if (last_gb) m_ptr = 1'b0;
      if (r.v) begin
         if (m_cnt < 65535) m_cnt++;
         e       = (r.shift >= 17) ? 0 : r.shift;
         m_left  = e;
         m_right = (17 - e) % 17;
         for (int i = 0; i < 16; i++) m_merge[i] = (i <= 15 - e);
      end
      hist.push_back(r);
      void'(hist.pop_front());
      @(posedge sys_clk);
      #1;
      rs = hist[2];
      ro = hist[0];
      chk("sel_valid", sel_valid, rs.v);
      chk("left_sel",  left_sel,  m_left);
      chk("right_sel", right_sel, m_right);
      chk("merge_sel", merge_sel, m_merge);
      chk("shift_err", shift_err, rs.v && (rs.shift >= 17));
      chk("out_valid", out_valid, ro.v);
      if (ro.v) begin
         chk("out_src", out_src, ro.src);
         chk("out_tag", out_tag, ro.tag);
         srcs.push_back(out_src);
      end
      chk("issue_cnt", issue_cnt, m_cnt);
      @(negedge sys_clk);
   endtask

   task automatic do_reset();
      rstn    = 1'b0;
      a_valid = 1'b0;
      b_valid = 1'b0;
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_sel_valid", sel_valid, 1'b0);
      chk("rst_issue_cnt", issue_cnt, 16'h0);
      chk("rst_left_sel",  left_sel,  5'h0);
      chk("rst_merge_sel", merge_sel, 16'h0);
      chk("rst_shift_err", shift_err, 1'b0);
      model_clear();
      @(posedge sys_clk);
      @(negedge sys_clk);
      rstn = 1'b1;
   endtask

   task automatic idle(input int n);
      a_valid = 1'b0;
      b_valid = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      model_clear();
      @(negedge sys_clk);
      do_reset();

      // single request on A, shift 5
      a_valid = 1'b1; a_shift = 5'd5; a_tag = 8'h11;
      step();
      chk("single_left",  left_sel,  5'd5);
      chk("single_right", right_sel, 5'd12);
      chk("single_merge", merge_sel, 16'h07FF);
      idle(3);

      // boundary encodings back to back
      a_valid = 1'b1; a_shift = 5'd0;  a_tag = 8'h20; step();
      chk("s0_merge", merge_sel, 16'hFFFF);
      a_shift = 5'd16; a_tag = 8'h21; step();
      chk("s16_right", right_sel, 5'd1);
      a_shift = 5'd1;  a_tag = 8'h22; step();
      chk("s1_merge", merge_sel, 16'h7FFF);
      idle(3);

      // contention right after reset: grants alternate A, B, A, B
      do_reset();
      srcs = {};
      a_valid = 1'b1; b_valid = 1'b1;
      a_shift = 5'd3; a_tag = 8'hA0; b_shift = 5'd9; b_tag = 8'hB0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (last_ga) begin a_shift = 5'($urandom_range(0, 16)); a_tag = 8'($urandom); end
         if (last_gb) begin b_shift = 5'($urandom_range(0, 16)); b_tag = 8'($urandom); end
      end
      idle(3);
      chk("contention_cnt", srcs.size(), 4);
      if (srcs.size() == 4) begin
         chk("contention_src0", srcs[0], 1'b0);
         chk("contention_src1", srcs[1], 1'b1);
         chk("contention_src2", srcs[2], 1'b0);
         chk("contention_src3", srcs[3], 1'b1);
      end

      // out-of-range shift on B
      b_valid = 1'b1; b_shift = 5'd20; b_tag = 8'h7E;
      step();
      chk("oor_err", shift_err, 1'b1);
      chk("oor_merge", merge_sel, 16'hFFFF);
      b_valid = 1'b0;
      step();
      chk("oor_err_pulse", shift_err, 1'b0);
      step();
      chk("oor_out_valid", out_valid, 1'b1);
      chk("oor_out_tag", out_tag, 8'h7E);
      idle(2);

      // random traffic honouring the hold-until-ready rule
      for (int n = 0; n < 300; n++) begin
         if (!a_valid) begin a_valid = 1'($urandom); a_shift = 5'($urandom); a_tag = 8'($urandom); end
         if (!b_valid) begin b_valid = 1'($urandom); b_shift = 5'($urandom); b_tag = 8'($urandom); end
         step();
         if (last_ga) a_valid = 1'b0;
         if (last_gb) b_valid = 1'b0;
      end
      idle(3);

      // reset with two requests in flight
      a_valid = 1'b1; b_valid = 1'b0; a_shift = 5'd7; a_tag = 8'h31; step();
      a_tag = 8'h32; step();
      do_reset();
      idle(4);
      chk("mid_rst_cnt", issue_cnt, 16'h0);
      a_valid = 1'b1; b_valid = 1'b1; a_tag = 8'h40; b_tag = 8'h41;
      step();
      chk("mid_rst_ptr_a", last_ga, 1'b1);
      idle(3);

      // saturation of the accept counter
      a_valid = 1'b1; b_valid = 1'b0;
      for (int n = 0; n < 65537; n++) begin
         a_shift = 5'($urandom); a_tag = 8'($urandom);
         step();
      end
      chk("sat_cnt", issue_cnt, 16'hFFFF);
      idle(3);
      chk("sat_hold", issue_cnt, 16'hFFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/qsn_shift_sched_len17.md
Name: qsn_shift_sched_len17

Overview:
- Two-requester scheduler and configurator for the 17-lane, 4-bit-plane QSN cyclic shifter used in partial message passing.
- Arbitrates shift requests from the CNU-read path (port A) and the VNU-write-back path (port B) using round-robin.
- Converts each granted shift amount into left_sel/right_sel/merge_sel.
- Tracks each issued shift through the shifter's fixed pipeline, so the consumer knows when sw_out is valid, which requester it belongs to, and which tag it carries.

Parameters:
- Z, 17, circulant size (number of QSN lanes); shift amounts are valid in 0..Z-1.
- SEL_W, 5, width of left_sel/right_sel.
- MRG_W, 16, width of merge_sel (Z-1).
- QSN_LAT, 2, cycles from selects presented at the QSN inputs to matching data at sw_out.
- TAG_W, 8, opaque requester tag width.

Ports:
- sys_clk  in  1  clock.
- rstn  in  1  reset, asynchronous assert, active-low.
- a_valid  in  1  port A request valid.
- a_ready  out  1  port A accepted this cycle.
- a_shift  in  5  port A shift amount.
- a_tag  in  TAG_W  port A tag.
- b_valid, b_ready, b_shift, b_tag: as port A, for port B.
- left_sel  out  SEL_W  to QSN left_sel.
- right_sel  out  SEL_W  to QSN right_sel.
- merge_sel  out  MRG_W  to QSN merge_sel (QSN delays it internally by one cycle).
- sel_valid  out  1  selects carry a live request this cycle.
- out_valid  out  1  QSN sw_out holds shifted data for a live request.
- out_src  out  1  0 = port A, 1 = port B, qualified by out_valid.
- out_tag  out  TAG_W  tag of that request.
- shift_err  out  1  one-cycle pulse: an accepted shift was >= Z.
- issue_cnt  out  16  saturating count of accepted requests.

Behaviour:
- Reset: all outputs are 0; the round-robin pointer is 0 (port A has priority first); the pipeline tracker is cleared.
- Handshake:
  - xx_ready is combinational, from arbitration on the current valids.
  - At most one grant per cycle.
  - The requester must hold valid, shift and tag stable until ready.
  - There is no backpressure from the QSN. A grant is issued every cycle a request is present.
- Arbitration:
  - Only one valid: that port is granted.
  - Both valid: the port named by the rr pointer is granted.
  - After any grant, the pointer moves to the other port.
  - No grant: the pointer is held.
- Select encoding:
  - Registered; appears the cycle after the handshake, with sel_valid=1.
  - For shift s in 0..16: left_sel = s; right_sel = (Z - s) mod Z; merge_sel has bits [15-s:0] = 1 and the rest 0. So s=0 gives 0xFFFF and s=16 gives 0x0000.
- Out-of-range shift (s >= 17):
  - The request is still accepted and encoded as s=0.
  - shift_err pulses in the same cycle as the selects.
  - The request still produces out_valid.
- Idle cycle: sel_valid=0; left_sel, right_sel and merge_sel hold their last values (keeps the QSN quiet).
- Tracker:
  - A QSN_LAT-deep shift register of {valid, src, tag}, loaded from the sel stage.
  - out_valid, out_src and out_tag equal the sel-stage values delayed by QSN_LAT cycles.
  - Total latency from handshake to out_valid is 1 + QSN_LAT = 3 cycles.
  - Fully pipelined: back-to-back grants give back-to-back out_valid.
- issue_cnt: increments on each handshake and saturates at 0xFFFF.
- Reset asserted mid-operation: in-flight tracker entries are discarded. No out_valid is produced after rstn deasserts for requests accepted before the reset.

Decomposition:
- Shared package qsn_pkg holds:
  - constants Z, SEL_W, MRG_W, QSN_LAT;
  - function shift_to_sel(s) returning {left, right, merge};
  - typedef qsn_trk_t {valid, src, tag}.
- One sub-module, qsn_rr_arb2: 2-way round-robin arbiter with its pointer register.

Test Plan:
- Single request, A, s=5, tag=0x11, at cycle 0:
  - a_ready=1 at cycle 0.
  - Cycle 1: left_sel=5, right_sel=12, merge_sel=0x07FF, sel_valid=1.
  - Cycle 3: out_valid=1, out_src=0, out_tag=0x11.
- Boundary encodings:
  - s=0 gives {0, 0, 0xFFFF}.
  - s=16 gives {16, 1, 0x0000}.
  - s=1 gives {1, 16, 0x7FFF}.
- Contention: A and B valid for 4 consecutive cycles after reset.
  - Grants are A, B, A, B.
  - out_src sequence is 0,1,0,1 on 4 consecutive out_valid cycles.
- Out-of-range: B, s=20, tag=0x7E.
  - Selects are {0, 0, 0xFFFF}.
  - shift_err pulses for 1 cycle.
  - out_valid with out_tag=0x7E 2 cycles later.
- Reset mid-flight: 2 requests accepted, then rstn low for 1 cycle, then released.
  - No out_valid afterwards.
  - issue_cnt=0.
  - rr pointer favours A.
- Saturation: preload via 65537 accepts; issue_cnt stays at 0xFFFF.
